exec_stage: RTL and testbench

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/rvcpu_pkg.sv | 33 +++
 rtl/exec_stage_alu.sv | 45 ++++
 rtl/exec_stage.sv | 112 +++++++++++
 tb/tb_exec_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvcpu_pkg.sv
// Shared CPU types: ALU opcodes, ALU flags and the execute-stage result payload.
package rvcpu;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [2:0] {
        alu_add,
        alu_and,
        alu_or,
        alu_xor,
        alu_sll,
        alu_srl,
        alu_sra,
        alu_slt
    } alu_op_t;

    // Flags always describe the adder (a + b, or a - b when b is inverted).
    typedef struct packed {
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
    } alu_flags_t;

    typedef struct packed {
        logic [XLEN-1:0]   res;
        alu_flags_t        flags;
        logic [REG_AW-1:0] rd;
        logic              wr_en;
    } ex_result_t;

endpackage

// File: rtl/exec_stage_alu.sv
// Combinational ALU; flags come from the adder so the caller can derive compares.
module alu
    import rvcpu::*;
#(
    parameter int unsigned Width = 32
) (
    input  alu_op_t          op,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic             invert_b,
    output logic [Width-1:0] res_c,
    output alu_flags_t       flags_c
);

    localparam int unsigned ShW = $clog2(Width);

    logic [Width-1:0] b_eff;
    logic [Width:0]   sum;
    logic [ShW-1:0]   shamt;

    always_comb begin
        b_eff = invert_b ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + (Width+1)'(invert_b);
        shamt = b[ShW-1:0];

        flags_c.carry    = sum[Width];
        flags_c.negative = sum[Width-1];
        flags_c.zero     = (sum[Width-1:0] == '0);
        flags_c.overflow = (a[Width-1] == b_eff[Width-1]) && (sum[Width-1] != a[Width-1]);

        res_c = '0;
        unique case (op)
            alu_add: res_c = sum[Width-1:0];
            alu_and: res_c = a & b;
            alu_or:  res_c = a | b;
            alu_xor: res_c = a ^ b;
            alu_sll: res_c = a << shamt;
            alu_srl: res_c = a >> shamt;
            alu_sra: res_c = Width'($signed(a) >>> shamt);
            alu_slt: res_c = sum[Width-1:0];
            default: res_c = '0;
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: one ALU feeding a valid/ready output register.
// Define RVCPU_EX_SKID_EN to add a 1-entry skid buffer and register in_ready.
module exec_stage
    import rvcpu::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  rvcpu::alu_op_t     in_op,
    input  logic [Width-1:0]   in_a,
    input  logic [Width-1:0]   in_b,
    input  logic               in_invert_b,
    input  logic               in_cmp_unsigned,
    input  logic [REG_AW-1:0]  in_rd,
    input  logic               in_wr_en,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Width-1:0]   out_res,
    output rvcpu::alu_flags_t  out_flags,
    output logic [REG_AW-1:0]  out_rd,
    output logic               out_wr_en
);

    logic [Width-1:0] alu_res_c;
    alu_flags_t       alu_flags_c;
    logic             lt_c;
    logic             capture_c;
    ex_result_t       cap_c;
    ex_result_t       out_q;
    logic             out_valid_q;

    alu #(.Width(Width)) u_alu (
        .op       (in_op),
        .a        (in_a),
        .b        (in_b),
        .invert_b (in_invert_b),
        .res_c    (alu_res_c),
        .flags_c  (alu_flags_c)
    );

    // Compare result from the subtract flags; rd 0 never writes back.
    always_comb begin
        lt_c          = in_cmp_unsigned ? ~alu_flags_c.carry
                                        : (alu_flags_c.negative ^ alu_flags_c.overflow);
        cap_c.res     = (in_op == alu_slt) ? XLEN'(lt_c) : XLEN'(alu_res_c);
        cap_c.flags   = alu_flags_c;
        cap_c.rd      = in_rd;
        cap_c.wr_en   = in_wr_en && (in_rd != '0);
        capture_c     = in_valid && in_ready;
    end

`ifdef RVCPU_EX_SKID_EN
    ex_result_t skid_q;
    logic       skid_valid_q;

    assign in_ready = ~skid_valid_q;

    // Skid drains into the output before any new op is taken, keeping order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (capture_c) begin
                out_q       <= cap_c;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (capture_c) begin
            skid_q       <= cap_c;
            skid_valid_q <= 1'b1;
        end
    end
`else
    assign in_ready = ~out_valid_q | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (capture_c) begin
            out_q       <= cap_c;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_res   = Width'(out_q.res);
    assign out_flags = out_q.flags;
    assign out_rd    = out_q.rd;
    assign out_wr_en = out_q.wr_en;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: directed corner cases then randomized traffic.
module tb_exec_stage;
    import rvcpu::*;

    localparam int unsigned W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    alu_op_t          in_op;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_invert_b;
    logic             in_cmp_unsigned;
    logic [4:0]       in_rd;
    logic             in_wr_en;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_res;
    alu_flags_t       out_flags;
    logic [4:0]       out_rd;
    logic             out_wr_en;

    ex_result_t exp_q[$];
    int         n_checks;
    int         n_fail;
    int         n_deliv;
    bit         rand_en;

    always #5 clk = ~clk;

    exec_stage #(.Width(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_op           (in_op),
        .in_a            (in_a),
        .in_b            (in_b),
        .in_invert_b     (in_invert_b),
        .in_cmp_unsigned (in_cmp_unsigned),
        .in_rd           (in_rd),
        .in_wr_en        (in_wr_en),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_res         (out_res),
        .out_flags       (out_flags),
        .out_rd          (out_rd),
        .out_wr_en       (out_wr_en)
    );

    // Reference: arithmetic on wide integers, compares done directly on values.
    function automatic ex_result_t model(input alu_op_t op, input logic [31:0] a,
                                         input logic [31:0] b, input bit inv, input bit uns,
                                         input logic [4:0] rd, input bit we);
        ex_result_t      r;
        longint unsigned usum;
        longint          ssum;
        logic [31:0]     s;
        logic [4:0]      sh;
        bit              lt;
        if (inv) begin
            usum = 64'(a) + (64'h1_0000_0000 - 64'(b));
            ssum = longint'($signed(a)) - longint'($signed(b));
        end else begin
            usum = 64'(a) + 64'(b);
            ssum = longint'($signed(a)) + longint'($signed(b));
        end
        s  = usum[31:0];
        sh = b[4:0];
        r.flags.carry    = usum[32];
        r.flags.negative = s[31];
        r.flags.zero     = (s == 32'd0);
        r.flags.overflow = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
        lt = uns ? (a < b) : ($signed(a) < $signed(b));
        case (op)
            alu_add: r.res = s;
            alu_and: r.res = a & b;
            alu_or:  r.res = a | b;
            alu_xor: r.res = a ^ b;
            alu_sll: r.res = a << sh;
            alu_srl: r.res = a >> sh;
            alu_sra: r.res = 32'($signed(a) >>> sh);
            default: r.res = {31'd0, lt};
        endcase
        r.rd    = rd;
        r.wr_en = we && (rd != 5'd0);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] cur_pay();
        return 64'({out_res, out_flags, out_rd, out_wr_en});
    endfunction

    // Pops on every delivered op and watches output stability under stall.
    task automatic monitor();
        logic [63:0] held = '0;
        bit          stall_hold = 1'b0;
        ex_result_t  e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                stall_hold = 1'b0;
                continue;
            end
            if (stall_hold && out_valid)
                check("hold_stable", cur_pay(), held);
            stall_hold = out_valid && !out_ready && !flush;
            held       = cur_pay();
            if (out_valid && out_ready) begin
                n_deliv++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_unexpected: actual=%0h required=none", cur_pay());
                end else begin
                    e = exp_q.pop_front();
                    check("out_payload", cur_pay(), 64'(e));
                end
            end
            if (flush)
                exp_q.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_en) begin
            if ($urandom_range(0, 19) == 0) begin
                flush     = 1'b1;
                out_ready = 1'b0;
            end else begin
                flush     = 1'b0;
                out_ready = ($urandom_range(0, 2) != 0);
            end
        end
    endtask

    task automatic set_in(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input bit inv, input bit uns, input logic [4:0] rd, input bit we);
        in_op = op; in_a = a; in_b = b; in_invert_b = inv;
        in_cmp_unsigned = uns; in_rd = rd; in_wr_en = we;
    endtask

    // Holds an op until accepted; the expectation is queued at acceptance.
    task automatic drive(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input bit inv, input bit uns, input logic [4:0] rd, input bit we);
        bit ok = 1'b0;
        set_in(op, a, b, inv, uns, rd, we);
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            if (ok && !flush)
                exp_q.push_back(model(op, a, b, inv, uns, rd, we));
            tick();
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 64'(ok), 64'(1));
    endtask

    initial begin
        int          base;
        logic [31:0] corners [4];
        logic [31:0] ra, rb;
        alu_op_t     rop;
        bit          rinv;
        corners = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        n_checks = 0; n_fail = 0; n_deliv = 0; rand_en = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_in(alu_add, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);

        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_payload", cur_pay(), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        fork monitor(); join_none
        tick();

        // add 5 + 7, one-cycle latency
        drive(alu_add, 32'd5, 32'd7, 1'b0, 1'b0, 5'd3, 1'b1);
        check("add_valid", 64'(out_valid), 64'(1));
        check("add_res", 64'(out_res), 64'd12);
        check("add_carry", 64'(out_flags.carry), 64'(0));

        // signed vs unsigned slt on -1 < 1
        drive(alu_slt, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 5'd4, 1'b1);
        check("slt_signed", 64'(out_res), 64'd1);
        drive(alu_slt, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 5'd4, 1'b1);
        check("sltu", 64'(out_res), 64'd0);
        tick(); tick();

        // three ops with the output stalled for two cycles after the first
        base = n_deliv;
        out_ready = 1'b0;
        drive(alu_add, 32'd10, 32'd20, 1'b0, 1'b0, 5'd1, 1'b1);
        fork
            begin
                drive(alu_xor, 32'hF0F0_0000, 32'h0FF0_1234, 1'b0, 1'b0, 5'd2, 1'b1);
                drive(alu_sra, 32'h8000_0010, 32'd4, 1'b0, 1'b0, 5'd5, 1'b0);
            end
            begin
                tick(); tick();
                out_ready = 1'b1;
            end
        join
        repeat (5) tick();
        check("b2b_delivered", 64'(n_deliv - base), 64'd3);
        check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

        // flush with a held output and a same-cycle input op
        out_ready = 1'b0;
        drive(alu_add, 32'd1, 32'd1, 1'b0, 1'b0, 5'd6, 1'b1);
        set_in(alu_or, 32'h1234, 32'h4321, 1'b0, 1'b0, 5'd7, 1'b1);
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        check("flush_out_valid", 64'(out_valid), 64'(0));
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        base = n_deliv;
        repeat (3) tick();
        check("flush_no_delivery", 64'(n_deliv - base), 64'd0);

        // rd 0 suppresses writeback
        drive(alu_add, 32'd9, 32'd9, 1'b0, 1'b0, 5'd0, 1'b1);
        check("rd0_valid", 64'(out_valid), 64'(1));
        check("rd0_wr_en", 64'(out_wr_en), 64'(0));
        tick();

        // reset pulse while the output is stalled
        out_ready = 1'b0;
        drive(alu_and, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 5'd8, 1'b1);
        set_in(alu_add, 32'd3, 32'd4, 1'b0, 1'b0, 5'd9, 1'b1);
        in_valid = 1'b1;
        @(negedge clk);
        if (in_ready) exp_q.push_back(model(alu_add, 32'd3, 32'd4, 1'b0, 1'b0, 5'd9, 1'b1));
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'(0));
        check("rst_mid_in_ready", 64'(in_ready), 64'(1));
        check("rst_mid_payload", cur_pay(), 64'(0));
        tick(); tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        base      = n_deliv;
        repeat (4) tick();
        check("rst_no_delivery", 64'(n_deliv - base), 64'd0);

        // randomized traffic with random backpressure and flushes
        rand_en = 1'b1;
        for (int k = 0; k < 300; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            rop  = alu_op_t'(3'($urandom_range(0, 7)));
            ra   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom();
            rb   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom();
            rinv = (rop == alu_slt) ? 1'b1 : ((rop == alu_add) ? 1'($urandom_range(0, 1)) : 1'b0);
            drive(rop, ra, rb, rinv, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
        rand_en   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_out_idle", 64'(out_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
